// File: rtl/cgra_host_launcher.sv
// Host-side launcher for a single CGRA kernel run: streams input words into the data BRAM,
// runs the Start/Done handshake with the CGRA, then streams result words back out.
module cgra_host_launcher #(
    parameter int SYS_DWIDTH     = 32,
    parameter int BYTE_LEN       = 4,
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1 << 20
) (
    input  logic                  Clk,
    input  logic                  Resetn,
    input  logic                  Cfg_Valid,
    output logic                  Cfg_Ready,
    input  logic [LEN_WIDTH-1:0]  Cfg_Load_Len,
    input  logic [LEN_WIDTH-1:0]  Cfg_Store_Base,
    input  logic [LEN_WIDTH-1:0]  Cfg_Store_Len,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    input  logic [SYS_DWIDTH-1:0] In_Data,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic [SYS_DWIDTH-1:0] Out_Data,
    output logic                  Out_Last,
    output logic                  Bram_En,
    output logic [BYTE_LEN-1:0]   Bram_Wen,
    output logic [SYS_DWIDTH-1:0] Bram_Addr,
    output logic [SYS_DWIDTH-1:0] Bram_Data_To_Bram,
    input  logic [SYS_DWIDTH-1:0] Bram_Data_From_Bram,
    output logic                  Computation_Start,
    input  logic                  Computation_Done,
    output logic                  Busy,
    output logic                  Run_Done,
    output logic                  Error
);

    localparam int ADDR_SHIFT = $clog2(BYTE_LEN);
    localparam int TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_DONE,
        RELEASE,
        UNLOAD
    } state_t;

    state_t state_reg, state_next;

    logic [LEN_WIDTH-1:0] load_len_reg;
    logic [LEN_WIDTH-1:0] store_base_reg;
    logic [LEN_WIDTH-1:0] store_len_reg;
    logic [LEN_WIDTH-1:0] load_cnt_reg;
    logic [LEN_WIDTH-1:0] rd_cnt_reg;
    logic [TMO_W-1:0]     tmo_reg;
    logic                 start_reg;
    logic                 run_done_reg;
    logic                 error_reg;

    // Read-pipeline tracking: one outstanding read at most per cycle of BRAM latency
    logic                 rd_pend_reg;
    logic                 rd_pend_last_reg;

    // Two-entry skid FIFO holding read data until the output stream accepts it
    logic [SYS_DWIDTH-1:0] skid_data_reg [2];
    logic                  skid_last_reg [2];
    logic                  skid_wr_ptr_reg;
    logic                  skid_rd_ptr_reg;
    logic [1:0]            skid_cnt_reg;

    logic                  cfg_accept;
    logic                  load_wr;
    logic                  rd_issue;
    logic                  timeout_hit;
    logic                  finish_empty;
    logic                  finish_unload;
    logic                  push;
    logic                  pop;
    logic                  head_last;
    logic [2:0]            fill_next;
    logic [LEN_WIDTH-1:0]  word_idx;
    logic [SYS_DWIDTH-1:0] addr_word;

    assign push      = rd_pend_reg;
    assign pop       = Out_Valid && Out_Ready;
    assign head_last = skid_last_reg[skid_rd_ptr_reg];
    // Slots in use once this cycle's pop is accounted for; lets reads stream at full rate
    assign fill_next = 3'(skid_cnt_reg) + 3'(rd_pend_reg) - 3'(pop);

    always_comb begin
        state_next    = state_reg;
        cfg_accept    = 1'b0;
        load_wr       = 1'b0;
        rd_issue      = 1'b0;
        timeout_hit   = 1'b0;
        finish_empty  = 1'b0;
        finish_unload = 1'b0;
        case (state_reg)
            IDLE: begin
                if (Cfg_Valid) begin
                    cfg_accept = 1'b1;
                    state_next = (Cfg_Load_Len == '0) ? START : LOAD;
                end
            end
            LOAD: begin
                if (In_Valid) begin
                    load_wr = 1'b1;
                    if (load_cnt_reg == load_len_reg - LEN_WIDTH'(1)) begin
                        state_next = START;
                    end
                end
            end
            START: begin
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                // Done wins over a timeout landing on the same cycle
                if (Computation_Done) begin
                    state_next = RELEASE;
                end else if (tmo_reg == TMO_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            RELEASE: begin
                if (!Computation_Done) begin
                    if (store_len_reg == '0) begin
                        finish_empty = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        state_next = UNLOAD;
                    end
                end
            end
            UNLOAD: begin
                rd_issue = (rd_cnt_reg != store_len_reg) && (fill_next < 3'd2);
                if (pop && head_last) begin
                    finish_unload = 1'b1;
                    state_next    = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        word_idx          = load_wr ? load_cnt_reg : (store_base_reg + rd_cnt_reg);
        addr_word         = SYS_DWIDTH'(word_idx);
        Bram_En           = load_wr || rd_issue;
        Bram_Wen          = load_wr ? '1 : '0;
        Bram_Addr         = Bram_En ? (addr_word << ADDR_SHIFT) : '0;
        Bram_Data_To_Bram = load_wr ? In_Data : '0;
    end

    assign Cfg_Ready         = (state_reg == IDLE);
    assign Busy              = (state_reg != IDLE);
    assign In_Ready          = (state_reg == LOAD);
    assign Computation_Start = start_reg;
    assign Run_Done          = run_done_reg;
    assign Error             = error_reg;
    assign Out_Valid         = (skid_cnt_reg != 2'd0);
    assign Out_Data          = skid_data_reg[skid_rd_ptr_reg];
    assign Out_Last          = Out_Valid && head_last;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_reg      <= IDLE;
            load_len_reg   <= '0;
            store_base_reg <= '0;
            store_len_reg  <= '0;
            start_reg      <= 1'b0;
            run_done_reg   <= 1'b0;
            error_reg      <= 1'b0;
            tmo_reg        <= '0;
        end else begin
            state_reg    <= state_next;
            // Start is high for exactly the WAIT_DONE cycles, straight from a flop
            start_reg    <= (state_next == WAIT_DONE);
            run_done_reg <= finish_empty || finish_unload;
            tmo_reg      <= (state_reg == WAIT_DONE) ? tmo_reg + TMO_W'(1) : '0;
            if (cfg_accept) begin
                load_len_reg   <= Cfg_Load_Len;
                store_base_reg <= Cfg_Store_Base;
                store_len_reg  <= Cfg_Store_Len;
                error_reg      <= 1'b0;
            end else if (timeout_hit) begin
                error_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            load_cnt_reg     <= '0;
            rd_cnt_reg       <= '0;
            rd_pend_reg      <= 1'b0;
            rd_pend_last_reg <= 1'b0;
        end else begin
            if (cfg_accept) begin
                load_cnt_reg <= '0;
                rd_cnt_reg   <= '0;
            end else begin
                if (load_wr) begin
                    load_cnt_reg <= load_cnt_reg + LEN_WIDTH'(1);
                end
                if (rd_issue) begin
                    rd_cnt_reg <= rd_cnt_reg + LEN_WIDTH'(1);
                end
            end
            rd_pend_reg      <= rd_issue;
            rd_pend_last_reg <= rd_issue && (rd_cnt_reg == store_len_reg - LEN_WIDTH'(1));
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            skid_wr_ptr_reg <= 1'b0;
            skid_rd_ptr_reg <= 1'b0;
            skid_cnt_reg    <= 2'd0;
        end else begin
            if (push) begin
                skid_wr_ptr_reg <= ~skid_wr_ptr_reg;
            end
            if (pop) begin
                skid_rd_ptr_reg <= ~skid_rd_ptr_reg;
            end
            skid_cnt_reg <= skid_cnt_reg + 2'(push) - 2'(pop);
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_skid
        always_ff @(posedge Clk or negedge Resetn) begin
            if (!Resetn) begin
                skid_data_reg[gi] <= '0;
                skid_last_reg[gi] <= 1'b0;
            end else if (push && (skid_wr_ptr_reg == 1'(gi))) begin
                skid_data_reg[gi] <= Bram_Data_From_Bram;
                skid_last_reg[gi] <= rd_pend_last_reg;
            end
        end
    end

endmodule

// File: tb/tb_cgra_host_launcher.sv
// Bench for cgra_host_launcher: BRAM model with a CGRA-side write port, scripted CGRA
// handshake, and a queue scoreboard for the result stream.
module tb_cgra_host_launcher;

    localparam int DW  = 32;
    localparam int BL  = 4;
    localparam int LW  = 16;
    localparam int TMO = 32;

    logic          Clk = 1'b0;
    logic          Resetn;
    logic          Cfg_Valid;
    logic          Cfg_Ready;
    logic [LW-1:0] Cfg_Load_Len;
    logic [LW-1:0] Cfg_Store_Base;
    logic [LW-1:0] Cfg_Store_Len;
    logic          In_Valid;
    logic          In_Ready;
    logic [DW-1:0] In_Data;
    logic          Out_Valid;
    logic          Out_Ready;
    logic [DW-1:0] Out_Data;
    logic          Out_Last;
    logic          Bram_En;
    logic [BL-1:0] Bram_Wen;
    logic [DW-1:0] Bram_Addr;
    logic [DW-1:0] Bram_Data_To_Bram;
    logic [DW-1:0] Bram_Data_From_Bram;
    logic          Computation_Start;
    logic          Computation_Done;
    logic          Busy;
    logic          Run_Done;
    logic          Error;

    logic          cgra_we;
    logic [7:0]    cgra_idx;
    logic [DW-1:0] cgra_data;
    logic [DW-1:0] mem [0:255];

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    logic [DW-1:0] rd_addr_q[$];
    logic [DW-1:0] out_data_q[$];
    logic          out_last_q[$];
    logic [DW-1:0] exp_q[$];
    int bram_en_cnt, start_cnt, run_done_cnt, stall_viol, cur_run, max_run;
    int start_fall, hold_reads;
    bit in_hs, stall_pending, start_seen;
    logic [DW-1:0] stall_data;
    logic stall_last;

    cgra_host_launcher #(
        .SYS_DWIDTH(DW), .BYTE_LEN(BL), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .Clk(Clk), .Resetn(Resetn),
        .Cfg_Valid(Cfg_Valid), .Cfg_Ready(Cfg_Ready),
        .Cfg_Load_Len(Cfg_Load_Len), .Cfg_Store_Base(Cfg_Store_Base), .Cfg_Store_Len(Cfg_Store_Len),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Data(In_Data),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Data(Out_Data), .Out_Last(Out_Last),
        .Bram_En(Bram_En), .Bram_Wen(Bram_Wen), .Bram_Addr(Bram_Addr),
        .Bram_Data_To_Bram(Bram_Data_To_Bram), .Bram_Data_From_Bram(Bram_Data_From_Bram),
        .Computation_Start(Computation_Start), .Computation_Done(Computation_Done),
        .Busy(Busy), .Run_Done(Run_Done), .Error(Error)
    );

    always #5 Clk = ~Clk;

    // Data BRAM: host port from the DUT, result-write port standing in for the CGRA
    always @(posedge Clk) begin
        if (cgra_we) mem[cgra_idx] <= cgra_data;
        if (Bram_En) begin
            if (Bram_Wen == 4'hF) mem[Bram_Addr[9:2]] <= Bram_Data_To_Bram;
            Bram_Data_From_Bram <= mem[Bram_Addr[9:2]];
        end
    end

    // Called at a falling edge with inputs already set; logs what the next rising edge will do
    task automatic tick();
        #1;
        in_hs = In_Valid && In_Ready;
        if (Bram_En) begin
            bram_en_cnt++;
            if (Bram_Wen == 4'hF) begin
                wr_addr_q.push_back(Bram_Addr);
                wr_data_q.push_back(Bram_Data_To_Bram);
            end else begin
                rd_addr_q.push_back(Bram_Addr);
            end
        end
        if (Out_Valid && Out_Ready) begin
            out_data_q.push_back(Out_Data);
            out_last_q.push_back(Out_Last);
        end
        if (stall_pending && (!Out_Valid || Out_Data !== stall_data || Out_Last !== stall_last))
            stall_viol++;
        stall_pending = Out_Valid && !Out_Ready;
        stall_data = Out_Data;
        stall_last = Out_Last;
        if (Out_Valid) begin
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
        end else begin
            cur_run = 0;
        end
        if (Computation_Start) start_cnt++;
        if (Run_Done) run_done_cnt++;
        @(negedge Clk);
    endtask

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        out_data_q.delete(); out_last_q.delete();
        bram_en_cnt = 0; start_cnt = 0; run_done_cnt = 0; stall_viol = 0;
        cur_run = 0; max_run = 0; start_fall = 0; hold_reads = 0;
        stall_pending = 0; start_seen = 0;
    endtask

    // CGRA-side result words; each value becomes an expected output word
    task automatic preload(input int base, input int st);
        logic [DW-1:0] v;
        for (int j = 0; j < st; j++) begin
            v = $urandom;
            cgra_we = 1'b1; cgra_idx = 8'(base + j); cgra_data = v;
            exp_q.push_back(v);
            tick();
        end
        cgra_we = 1'b0;
    endtask

    task automatic do_run(input int ld, input int base, input int st, input int delay,
                          input int hold, input bit rand_ready, input bit expect_done);
        int k, guard;
        clear_logs();
        Cfg_Valid = 1'b1; Cfg_Load_Len = LW'(ld); Cfg_Store_Base = LW'(base); Cfg_Store_Len = LW'(st);
        tick();
        Cfg_Valid = 1'b0;
        k = 0; guard = 0;
        while (k < ld && guard < ld + 20) begin
            In_Valid = 1'b1; In_Data = 32'hA000_0000 + DW'(k);
            tick();
            if (in_hs) k++;
            guard++;
        end
        In_Valid = 1'b0; In_Data = '0;
        guard = 0;
        while (!Computation_Start && guard < 10) begin tick(); guard++; end
        start_seen = Computation_Start;
        if (expect_done) begin
            repeat (delay) tick();
            Computation_Done = 1'b1;
            do begin tick(); start_fall++; end while (Computation_Start && start_fall < 20);
            repeat (hold) tick();
            hold_reads = rd_addr_q.size();
            Computation_Done = 1'b0;
        end else begin
            guard = 0;
            while (Computation_Start && guard < 100) begin tick(); guard++; end
        end
        guard = 0;
        while (expect_done && run_done_cnt == 0 && guard < 400) begin
            Out_Ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            guard++;
        end
        Out_Ready = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        repeat (3) @(negedge Clk);
        Resetn = 1'b1;
        #1;
        checks++;
        if ({Cfg_Ready, Busy, Computation_Start, Out_Valid, Bram_En, Run_Done, Error, In_Ready} !== 8'b1000_0000) begin
            failures++;
            $display("FAIL reset_flags: got %b want 10000000",
                     {Cfg_Ready, Busy, Computation_Start, Out_Valid, Bram_En, Run_Done, Error, In_Ready});
        end
        checks++;
        if ({Bram_Addr, Out_Data, Out_Last, Bram_Wen} !== '0) begin
            failures++;
            $display("FAIL reset_buses: addr=%h out=%h last=%b wen=%h want all 0", Bram_Addr, Out_Data, Out_Last, Bram_Wen);
        end
        @(negedge Clk);
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [DW-1:0] e;
        preload(8, 2);
        do_run(4, 8, 2, 5, 1, 1'b0, 1'b1);
        checks++;
        if (wr_addr_q.size() != 4) begin failures++; $display("FAIL basic_wr_count: got %0d want 4", wr_addr_q.size()); end
        for (int i = 0; i < wr_addr_q.size() && i < 4; i++) begin
            checks++;
            if (wr_addr_q[i] !== DW'(i * 4) || wr_data_q[i] !== 32'hA000_0000 + DW'(i)) begin
                failures++;
                $display("FAIL basic_write%0d: got addr=%h data=%h want addr=%h data=%h",
                         i, wr_addr_q[i], wr_data_q[i], i * 4, 32'hA000_0000 + DW'(i));
            end
        end
        checks++;
        if (rd_addr_q.size() != 2 || rd_addr_q[0] !== 32'h20 || rd_addr_q[1] !== 32'h24) begin
            failures++; $display("FAIL basic_reads: got %p want 0x20,0x24", rd_addr_q);
        end
        checks++;
        if (out_data_q.size() != 2) begin failures++; $display("FAIL basic_out_count: got %0d want 2", out_data_q.size()); end
        for (int i = 0; i < out_data_q.size(); i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            checks++;
            if (out_data_q[i] !== e || out_last_q[i] !== (i == 1)) begin
                failures++;
                $display("FAIL basic_out%0d: got %h last=%b want %h last=%b", i, out_data_q[i], out_last_q[i], e, i == 1);
            end
        end
        exp_q.delete();
        checks++;
        if (!start_seen || start_cnt != 6 || start_fall != 1) begin
            failures++; $display("FAIL basic_start: seen=%b cycles=%0d fall=%0d want 1,6,1", start_seen, start_cnt, start_fall);
        end
        checks++;
        if (run_done_cnt != 1 || Error !== 1'b0) begin
            failures++; $display("FAIL basic_done: run_done=%0d error=%b want 1,0", run_done_cnt, Error);
        end
        $display("test_basic done");
    endtask

    task automatic test_handshake();
        logic [DW-1:0] e;
        preload(4, 2);
        do_run(1, 4, 2, 3, 9, 1'b0, 1'b1);
        checks++;
        if (start_fall != 1) begin failures++; $display("FAIL hs_start_fall: got %0d cycles want 1", start_fall); end
        checks++;
        if (hold_reads != 0) begin failures++; $display("FAIL hs_reads_while_done: got %0d want 0", hold_reads); end
        checks++;
        if (rd_addr_q.size() != 2 || wr_addr_q.size() != 1) begin
            failures++; $display("FAIL hs_access_count: reads=%0d writes=%0d want 2,1", rd_addr_q.size(), wr_addr_q.size());
        end
        for (int i = 0; i < out_data_q.size(); i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            checks++;
            if (out_data_q[i] !== e) begin failures++; $display("FAIL hs_out%0d: got %h want %h", i, out_data_q[i], e); end
        end
        exp_q.delete();
        checks++;
        if (run_done_cnt != 1) begin failures++; $display("FAIL hs_run_done: got %0d want 1", run_done_cnt); end
        $display("test_handshake done");
    endtask

    task automatic test_random_ready();
        logic [DW-1:0] e;
        preload(100, 16);
        do_run(0, 100, 16, 2, 0, 1'b1, 1'b1);
        checks++;
        if (out_data_q.size() != 16) begin failures++; $display("FAIL rnd_out_count: got %0d want 16", out_data_q.size()); end
        for (int i = 0; i < out_data_q.size(); i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            checks++;
            if (out_data_q[i] !== e || out_last_q[i] !== (i == 15)) begin
                failures++;
                $display("FAIL rnd_out%0d: got %h last=%b want %h last=%b", i, out_data_q[i], out_last_q[i], e, i == 15);
            end
        end
        exp_q.delete();
        checks++;
        if (stall_viol != 0 || run_done_cnt != 1 || wr_addr_q.size() != 0) begin
            failures++;
            $display("FAIL rnd_misc: stall_changes=%0d run_done=%0d writes=%0d want 0,1,0", stall_viol, run_done_cnt, wr_addr_q.size());
        end
        $display("test_random_ready done");
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] e;
        preload(20, 16);
        do_run(0, 20, 16, 1, 0, 1'b0, 1'b1);
        checks++;
        if (max_run != 16) begin failures++; $display("FAIL b2b_valid_run: got %0d want 16", max_run); end
        checks++;
        if (rd_addr_q.size() != 16) begin failures++; $display("FAIL b2b_read_count: got %0d want 16", rd_addr_q.size()); end
        for (int j = 0; j < rd_addr_q.size(); j++) begin
            checks++;
            if (rd_addr_q[j] !== DW'((20 + j) * 4)) begin
                failures++; $display("FAIL b2b_read%0d: got %h want %h", j, rd_addr_q[j], (20 + j) * 4);
            end
        end
        for (int i = 0; i < out_data_q.size(); i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            checks++;
            if (out_data_q[i] !== e) begin failures++; $display("FAIL b2b_out%0d: got %h want %h", i, out_data_q[i], e); end
        end
        exp_q.delete();
        $display("test_back_to_back done");
    endtask

    task automatic test_wrap();
        logic [DW-1:0] e;
        preload(65535, 2);
        do_run(0, 65535, 2, 1, 0, 1'b0, 1'b1);
        checks++;
        if (rd_addr_q.size() != 2 || rd_addr_q[0] !== 32'h3FFFC || rd_addr_q[1] !== 32'h0) begin
            failures++; $display("FAIL wrap_reads: got %p want 0x3fffc,0x0", rd_addr_q);
        end
        for (int i = 0; i < out_data_q.size(); i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            checks++;
            if (out_data_q[i] !== e) begin failures++; $display("FAIL wrap_out%0d: got %h want %h", i, out_data_q[i], e); end
        end
        exp_q.delete();
        $display("test_wrap done");
    endtask

    task automatic test_empty();
        do_run(0, 0, 0, 2, 0, 1'b0, 1'b1);
        checks++;
        if (bram_en_cnt != 0) begin failures++; $display("FAIL empty_bram_en: got %0d accesses want 0", bram_en_cnt); end
        checks++;
        if (!start_seen || start_fall != 1 || run_done_cnt != 1) begin
            failures++; $display("FAIL empty_handshake: seen=%b fall=%0d run_done=%0d want 1,1,1", start_seen, start_fall, run_done_cnt);
        end
        $display("test_empty done");
    endtask

    task automatic test_timeout();
        do_run(0, 0, 2, 0, 0, 1'b0, 1'b0);
        checks++;
        if (start_cnt != TMO) begin failures++; $display("FAIL tmo_start_cycles: got %0d want %0d", start_cnt, TMO); end
        checks++;
        if (Error !== 1'b1 || run_done_cnt != 0 || rd_addr_q.size() != 0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL tmo_abort: error=%b run_done=%0d reads=%0d busy=%b want 1,0,0,0", Error, run_done_cnt, rd_addr_q.size(), Busy);
        end
        do_run(0, 0, 0, 1, 0, 1'b0, 1'b1);
        checks++;
        if (Error !== 1'b0 || run_done_cnt != 1) begin
            failures++; $display("FAIL tmo_clear: error=%b run_done=%0d want 0,1", Error, run_done_cnt);
        end
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid_unload();
        int guard;
        preload(0, 8);
        exp_q.delete();
        clear_logs();
        Cfg_Valid = 1'b1; Cfg_Load_Len = '0; Cfg_Store_Base = '0; Cfg_Store_Len = LW'(8);
        tick();
        Cfg_Valid = 1'b0;
        guard = 0;
        while (!Computation_Start && guard < 10) begin tick(); guard++; end
        Computation_Done = 1'b1;
        repeat (2) tick();
        Computation_Done = 1'b0;
        Out_Ready = 1'b1;
        repeat (5) tick();
        #1;
        checks++;
        if ({Out_Valid, Bram_En, Busy} !== 3'b111) begin
            failures++; $display("FAIL rstmid_pre: valid,en,busy=%b want 111", {Out_Valid, Bram_En, Busy});
        end
        Resetn = 1'b0;
        #1;
        checks++;
        if ({Computation_Start, Out_Valid, Bram_En} !== 3'b000) begin
            failures++; $display("FAIL rstmid_async: start,valid,en=%b want 000", {Computation_Start, Out_Valid, Bram_En});
        end
        @(negedge Clk);
        Resetn = 1'b1;
        Out_Ready = 1'b0;
        #1;
        checks++;
        if ({Cfg_Ready, Busy, Out_Valid} !== 3'b100) begin
            failures++; $display("FAIL rstmid_after: ready,busy,valid=%b want 100", {Cfg_Ready, Busy, Out_Valid});
        end
        @(negedge Clk);
        $display("test_reset_mid_unload done");
    endtask

    initial begin
        Resetn = 1'b0; Cfg_Valid = 1'b0; Cfg_Load_Len = '0; Cfg_Store_Base = '0; Cfg_Store_Len = '0;
        In_Valid = 1'b0; In_Data = '0; Out_Ready = 1'b0; Computation_Done = 1'b0;
        cgra_we = 1'b0; cgra_idx = '0; cgra_data = '0;
        clear_logs();
        @(negedge Clk);
        test_reset();
        test_basic();
        test_handshake();
        test_random_ready();
        test_back_to_back();
        test_wrap();
        test_empty();
        test_timeout();
        test_reset_mid_unload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
